// File: rtl/acc_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_share_pkg
// Purpose  : Shared types and constants for the acc_share_sched scheduler.
//            - state_t : scheduler FSM states
//            - default parameter values
//            - wide all-ones pattern used to build the saturation value
// Revision : 1.0  initial release
// ============================================================================
package acc_share_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 32;

  // Saturation value source; the top slices it down to WIDTH bits, so the
  // accumulator width is bounded by MAX_WIDTH.
  localparam int unsigned           MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0]  SAT_ONES  = '1;

endpackage : acc_share_pkg
`default_nettype wire

// File: rtl/acc_share_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority picker. Searches req_i from
//            ptr_i upward, wrapping NREQ-1 -> 0, and returns the first hit.
// Ports    : req_i   [NREQ]  request vector
//            ptr_i   [IDW]   search start position (must be < NREQ)
//            grant_o [NREQ]  one-hot grant, zero when no request
//            idx_o   [IDW]   index of the granted requester
//            any_o           a request was found
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/acc_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : acc_share_sched
// Purpose  : Round-robin scheduler sharing one saturating accumulate adder
//            (acc <= acc + inc) between NREQ requesters, with a single
//            registered response channel (sum, owner id, saturation flag).
// Ports    : clk, rst                 clock / synchronous active-high reset
//            req_valid_i [NREQ]       request present per requester
//            req_inc_i   [NREQ*WIDTH] increment, requester i at [i*WIDTH +: WIDTH]
//            req_ready_o [NREQ]       one-hot grant (or zero) this cycle
//            clr_i                    clear accumulator, beats any grant
//            resp_valid_o / resp_ready_i  response handshake
//            resp_id_o   [IDW]        requester that produced resp_sum_o
//            resp_sum_o  [WIDTH]      accumulator after that increment
//            resp_sat_o               the increment saturated the accumulator
//            acc_o       [WIDTH]      current accumulator value
// Revision : 1.0  initial release
// ============================================================================
module acc_share_sched
  import acc_share_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_inc_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic                  clr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [IDW-1:0]        resp_id_o,
  output logic [WIDTH-1:0]      resp_sum_o,
  output logic                  resp_sat_o,
  output logic [WIDTH-1:0]      acc_o
);

  localparam logic [WIDTH-1:0] C_SAT_ONES = SAT_ONES[WIDTH-1:0];

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [WIDTH-1:0] acc_q;
  logic             resp_valid_q;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_sum_q;
  logic             resp_sat_q;

  logic [NREQ-1:0]  w_pick_onehot;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_any;
  logic             w_grant_en;
  logic             w_grant;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] acc_d;
  logic [IDW:0]     w_idx_inc;
  logic [IDW-1:0]   ptr_d;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (w_pick_onehot),
    .idx_o   (w_pick_idx),
    .any_o   (w_pick_any)
  );

  // Grants need a free response slot: either nothing is pending or the
  // pending response leaves this cycle. A clear (input or state) blocks them.
  assign w_grant_en  = !rst && !clr_i && (state_q != CLEAR) &&
                       (!resp_valid_q || resp_ready_i);
  assign w_grant     = w_grant_en && w_pick_any;
  assign req_ready_o = w_grant_en ? w_pick_onehot : '0;

  // Adder sees only the registered accumulator, so there is no
  // combinational path from the response back into the sum.
  assign w_inc = req_inc_i[w_pick_idx*WIDTH +: WIDTH];
  assign w_sum = {1'b0, acc_q} + {1'b0, w_inc};
  assign acc_d = w_sum[WIDTH] ? C_SAT_ONES : w_sum[WIDTH-1:0];

  assign w_idx_inc = {1'b0, w_pick_idx} + 1'b1;
  assign ptr_d     = (w_idx_inc == (IDW+1)'(NREQ)) ? '0 : w_idx_inc[IDW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ptr_q        <= '0;
      acc_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_sat_q   <= 1'b0;
    end else begin
      // FSM: CLEAR while clr is high, otherwise track the response stall.
      if (clr_i) begin
        state_q <= CLEAR;
      end else if (resp_valid_q && !resp_ready_i) begin
        state_q <= STALL;
      end else begin
        state_q <= RUN;
      end

      if (clr_i) begin
        acc_q <= '0;
      end else if (w_grant) begin
        acc_q <= acc_d;
      end

      if (w_grant) begin
        ptr_q        <= ptr_d;
        resp_valid_q <= 1'b1;
        resp_id_q    <= w_pick_idx;
        resp_sum_q   <= acc_d;
        resp_sat_q   <= w_sum[WIDTH];
      end else if (resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_sum_o   = resp_sum_q;
  assign resp_sat_o   = resp_sat_q;
  assign acc_o        = acc_q;

endmodule : acc_share_sched
`default_nettype wire

// File: tb/tb_acc_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_share_sched
// Purpose  : Directed self-checking bench for acc_share_sched (NREQ=4,
//            WIDTH=32). Inputs change 1 ns after the rising edge; outputs
//            are sampled at least 1 ns after the edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_acc_share_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_inc;
  logic [NREQ-1:0]       req_ready;
  logic                  clr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_sat;
  logic [WIDTH-1:0]      acc;

  int checks = 0;
  int errors = 0;

  acc_share_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_inc_i    (req_inc),
    .req_ready_o  (req_ready),
    .clr_i        (clr),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_sum_o   (resp_sum),
    .resp_sat_o   (resp_sat),
    .acc_o        (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc(input int idx, input logic [WIDTH-1:0] v);
    req_inc[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic chk_resp(input string tag, input logic [IDW-1:0] id,
                          input logic [WIDTH-1:0] sum, input logic sat);
    chk({tag, "_valid"}, 64'(resp_valid), 64'(1'b1));
    chk({tag, "_id"},    64'(resp_id),    64'(id));
    chk({tag, "_sum"},   64'(resp_sum),   64'(sum));
    chk({tag, "_sat"},   64'(resp_sat),   64'(sat));
    chk({tag, "_acc"},   64'(acc),        64'(sum));
  endtask

  initial begin
    rst        = 1'b1;
    clr        = 1'b0;
    req_valid  = 4'b1111;
    req_inc    = '0;
    resp_ready = 1'b1;

    // Reset state; requests are present but must not be granted under rst.
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_id", 64'(resp_id), 64'h0);
    chk("rst_resp_sum", 64'(resp_sum), 64'h0);
    chk("rst_resp_sat", 64'(resp_sat), 64'h0);
    chk("rst_acc", 64'(acc), 64'h0);

    // 1: all requesters, inc=1 -> grants 0,1,2,3,0,... sums 1..8
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_inc(i, 32'd1);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t1_req_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk_resp("t1", IDW'(k % 4), WIDTH'(k + 1), 1'b0);
    end
    req_valid = 4'b0000;
    tick();
    chk("t1_drop_valid", 64'(resp_valid), 64'h0);
    chk("t1_acc_hold", 64'(acc), 64'd8);

    // Clear back to zero so the single-requester sums start at 0.
    clr = 1'b1;
    tick();
    chk("clr_acc", 64'(acc), 64'h0);
    clr = 1'b0;
    tick();

    // 2: only requester 2, inc=5 -> granted every cycle (ptr is 0 here)
    req_valid = 4'b0100;
    set_inc(2, 32'd5);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_req_ready", 64'(req_ready), 64'(4'b0100));
      tick();
      chk_resp("t2", 2'd2, WIDTH'(5 * (k + 1)), 1'b0);
    end

    // 3: consumer stalls with all requests valid; ptr=3, response 20/id 2
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_stall_ready", 64'(req_ready), 64'h0);
      tick();
      chk_resp("t3_hold", 2'd2, 32'd20, 1'b0);
    end
    resp_ready = 1'b1;
    #1;
    chk("t3_release_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    chk_resp("t3_next", 2'd3, 32'd21, 1'b0);
    req_valid = 4'b0000;
    tick();
    chk("t3_drop_valid", 64'(resp_valid), 64'h0);

    // 4: saturation via requester 1 (ptr=0); 21 + FFFF_FFDB = FFFF_FFF0
    req_valid = 4'b0010;
    set_inc(1, 32'hFFFF_FFDB);
    tick();
    chk_resp("t4_pre", 2'd1, 32'hFFFF_FFF0, 1'b0);
    set_inc(1, 32'h20);
    tick();
    chk_resp("t4_sat", 2'd1, 32'hFFFF_FFFF, 1'b1);
    set_inc(1, 32'h0);
    tick();
    chk_resp("t4_exact", 2'd1, 32'hFFFF_FFFF, 1'b0);
    set_inc(1, 32'hFFFF_FFFF);
    tick();
    chk_resp("t4_full", 2'd1, 32'hFFFF_FFFF, 1'b1);
    req_valid = 4'b0000;
    tick();

    // 5: clr together with a request from 0 (ptr=2)
    clr       = 1'b1;
    req_valid = 4'b0001;
    set_inc(0, 32'd7);
    #1;
    chk("t5_clr_ready", 64'(req_ready), 64'h0);
    tick();
    chk("t5_acc_cleared", 64'(acc), 64'h0);
    chk("t5_no_resp", 64'(resp_valid), 64'h0);
    clr = 1'b0;
    #1;
    chk("t5_clear_state_ready", 64'(req_ready), 64'h0);
    tick();
    chk("t5_acc_still0", 64'(acc), 64'h0);
    #1;
    chk("t5_grant_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    chk_resp("t5_resp", 2'd0, 32'd7, 1'b0);

    // 6: reset during a stalled response; ptr=1 before reset
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_inc(i, 32'd1);
    tick();
    chk_resp("t6_stalled", 2'd0, 32'd7, 1'b0);
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(resp_valid), 64'h0);
    chk("t6_rst_acc", 64'(acc), 64'h0);
    chk("t6_rst_sum", 64'(resp_sum), 64'h0);
    chk("t6_rst_ready", 64'(req_ready), 64'h0);
    rst        = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("t6_first_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    chk_resp("t6_first", 2'd0, 32'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_acc_share_sched
`default_nettype wire
